// File: rtl/move_link_if.sv
// move_link_if: byte-level UART handshake between move_link and the UART core
//   tx_data/tx_start : frame byte and one-cycle start strobe towards UART TX
//   tx_done          : one-cycle end-of-stop-bit pulse from UART TX
//   rx_data/rx_valid : received byte and its one-cycle valid strobe from UART RX
interface move_link_if;
    logic [7:0] tx_data;
    logic       tx_start;
    logic       tx_done;
    logic [7:0] rx_data;
    logic       rx_valid;
    modport master (output tx_data, tx_start, input tx_done, rx_data, rx_valid);
    modport slave  (input tx_data, tx_start, output tx_done, rx_data, rx_valid);
endinterface

// File: rtl/move_link.sv
// move_link: move framing, validation and board keeping between game FSM and UART
//   pclk, rst (sync, active-high), board_clr : clock, reset, board/pending clear pulse
//   mouse_xpos/ypos/left                      : cursor position and left button level
//   playerID, uart_en, write_uart_en, uart_mode : control FSM inputs (mode 0 send, 1 receive)
//   uart (move_link_if.master)                : tx_data/tx_start/tx_done/rx_data/rx_valid
//   rx_tx_done, square1to9, owner1to9, last_square, frame_err, link_timeout : status outputs
//   Optional receive watchdog: define MOVE_LINK_TIMEOUT_EN
module move_link #(
    parameter logic [26:0] TIMEOUT_CYCLES = 27'd100_000_000,
    parameter logic [1:0]  SYNC           = 2'b10
) (
    input  logic             pclk,
    input  logic             rst,
    input  logic             board_clr,
    input  logic [11:0]      mouse_xpos,
    input  logic [11:0]      mouse_ypos,
    input  logic             mouse_left,
    input  logic             playerID,
    input  logic             uart_en,
    input  logic             write_uart_en,
    input  logic             uart_mode,
    move_link_if.master      uart,
    output logic             rx_tx_done,
    output logic [8:0]       square1to9,
    output logic [8:0]       owner1to9,
    output logic [3:0]       last_square,
    output logic             frame_err,
    output logic             link_timeout
);
    typedef enum logic [2:0] {IDLE, TX_LOAD, TX_WAIT, RX_WAIT, DONE} state_t;
    state_t state, state_nx;
    logic       left_q, pend_v, commit, commit_own, rx_fail, rx_ok, col_v, row_v, click_ok;
    logic [1:0] col, row;
    logic [3:0] pend_sq, commit_sq, click_sq, rx_idx;
    logic [7:0] tx_frame;
    // Out-of-range x/y and the thin grid lines between squares decode to "no square"
    assign col      = mouse_xpos <= 12'd338 ? 2'd0 : mouse_xpos <= 12'd679 ? 2'd1 : 2'd2;
    assign row      = mouse_ypos <= 12'd251 ? 2'd0 : mouse_ypos <= 12'd507 ? 2'd1 : 2'd2;
    assign col_v    = mouse_xpos <= 12'd338 || (mouse_xpos >= 12'd344 && mouse_xpos <= 12'd679) ||
                      (mouse_xpos >= 12'd685 && mouse_xpos <= 12'd1023);
    assign row_v    = mouse_ypos <= 12'd251 || (mouse_ypos >= 12'd259 && mouse_ypos <= 12'd507) ||
                      (mouse_ypos >= 12'd515 && mouse_ypos <= 12'd767);
    assign click_sq = {1'b0, row, 1'b0} + {2'b00, row} + {2'b00, col};
    assign click_ok = mouse_left && !left_q && state == IDLE && !uart_mode &&
                      col_v && row_v && !square1to9[click_sq];
    assign tx_frame = {SYNC, playerID, ^pend_sq, pend_sq};
    assign rx_idx   = uart.rx_data[3:0];
    assign rx_ok    = uart.rx_data[7:6] == SYNC && rx_idx <= 4'd8 && uart.rx_data[4] == ^rx_idx &&
                      uart.rx_data[5] != playerID && !square1to9[rx_idx];
    always_comb begin
        state_nx      = state;
        uart.tx_data  = 8'h00;
        uart.tx_start = 1'b0;
        rx_tx_done    = 1'b0;
        commit        = 1'b0;
        commit_sq     = pend_sq;
        commit_own    = playerID;
        rx_fail       = 1'b0;
        case (state)
            IDLE:
                if (uart_en && write_uart_en)
                    state_nx = uart_mode ? RX_WAIT : pend_v ? TX_LOAD : IDLE;
            TX_LOAD: begin
                uart.tx_data  = tx_frame;
                uart.tx_start = uart_en;
                state_nx      = uart_en ? TX_WAIT : IDLE;
            end
            TX_WAIT: begin
                uart.tx_data = tx_frame;
                if (!uart_en)
                    state_nx = IDLE;
                else if (uart.tx_done) begin
                    commit   = 1'b1;
                    state_nx = DONE;
                end
            end
            RX_WAIT:
                if (!uart_en)
                    state_nx = IDLE;
                else if (uart.rx_valid) begin
                    commit     = rx_ok;
                    commit_sq  = rx_idx;
                    commit_own = uart.rx_data[5];
                    rx_fail    = !rx_ok;
                    state_nx   = rx_ok ? DONE : RX_WAIT;
                end
            DONE: begin
                rx_tx_done = 1'b1;
                state_nx   = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end
    always_ff @(posedge pclk) left_q <= rst ? 1'b0 : mouse_left;
    // board_clr shares the reset path so a coincident received byte is dropped
    always_ff @(posedge pclk) begin
        if (rst || board_clr) begin
            state       <= IDLE;
            square1to9  <= '0;
            owner1to9   <= '0;
            last_square <= 4'hF;
            pend_v      <= 1'b0;
            pend_sq     <= '0;
            frame_err   <= 1'b0;
        end else begin
            state     <= state_nx;
            frame_err <= rx_fail;
            if (commit) begin
                square1to9[commit_sq] <= 1'b1;
                owner1to9[commit_sq]  <= commit_own;
                last_square           <= commit_sq;
            end
            if (click_ok) begin
                pend_sq <= click_sq;
                pend_v  <= 1'b1;
            end
            if (commit && state == TX_WAIT)
                pend_v <= 1'b0;
        end
    end
`ifdef MOVE_LINK_TIMEOUT_EN
    logic [26:0] wd_cnt;
    always_ff @(posedge pclk) begin
        if (rst || board_clr) begin
            wd_cnt       <= '0;
            link_timeout <= 1'b0;
        end else if (state_nx == RX_WAIT && state != RX_WAIT)
            wd_cnt <= '0;
        else if (state == RX_WAIT) begin
            // wd_cnt counts completed RX_WAIT cycles; flag on the last one of the window
            if (wd_cnt == TIMEOUT_CYCLES - 27'd1) begin
                link_timeout <= 1'b1;
                wd_cnt       <= '0;
            end else
                wd_cnt <= wd_cnt + 27'd1;
        end
    end
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT_CYCLES;
    assign link_timeout   = 1'b0;
`endif
endmodule

// File: tb/tb_move_link.sv
// tb_move_link: randomized transaction bench for move_link against a board-level reference model
module tb_move_link;
    logic        pclk = 1'b0, rst = 1'b1, board_clr = 1'b0;
    logic [11:0] mouse_xpos = '0, mouse_ypos = '0;
    logic        mouse_left = 1'b0, playerID = 1'b0, uart_en = 1'b0, write_uart_en = 1'b0, uart_mode = 1'b0;
    logic        rx_tx_done, frame_err, link_timeout;
    logic [8:0]  square1to9, owner1to9;
    logic [3:0]  last_square;
    move_link_if u_if();
    move_link #(.TIMEOUT_CYCLES(27'd50)) dut (
        .pclk(pclk), .rst(rst), .board_clr(board_clr),
        .mouse_xpos(mouse_xpos), .mouse_ypos(mouse_ypos), .mouse_left(mouse_left),
        .playerID(playerID), .uart_en(uart_en), .write_uart_en(write_uart_en), .uart_mode(uart_mode),
        .uart(u_if.master), .rx_tx_done(rx_tx_done), .square1to9(square1to9), .owner1to9(owner1to9),
        .last_square(last_square), .frame_err(frame_err), .link_timeout(link_timeout)
    );
    always #5 pclk = ~pclk;
    int checks = 0, errors = 0;
    int n_start = 0, n_done = 0, n_ferr = 0;
    logic [7:0] last_tx = '0;
    bit occ[9], own[9];
    int last_m = 15, pend_sq_m = 0;
    bit pend_v_m = 0;
    always @(negedge pclk) if (!rst) begin
        if (u_if.tx_start) begin n_start++; last_tx = u_if.tx_data; end
        if (rx_tx_done) n_done++;
        if (frame_err) n_ferr++;
    end
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask
    function automatic int parity(input int v);
        int n = 0;
        for (int b = 0; b < 4; b++) n += (v >> b) & 1;
        return n % 2;
    endfunction
    function automatic logic [7:0] frame(input int idx, input int p);
        return 8'(128 + p * 32 + parity(idx) * 16 + idx);
    endfunction
    function automatic int decode(input int x, input int y);
        int c, r;
        c = x <= 338 ? 0 : (x >= 344 && x <= 679) ? 1 : (x >= 685 && x <= 1023) ? 2 : -1;
        r = y <= 251 ? 0 : (y >= 259 && y <= 507) ? 1 : (y >= 515 && y <= 767) ? 2 : -1;
        return (c < 0 || r < 0) ? -1 : r * 3 + c;
    endfunction
    task automatic clr_model();
        for (int i = 0; i < 9; i++) begin occ[i] = 0; own[i] = 0; end
        last_m = 15; pend_v_m = 0; pend_sq_m = 0;
    endtask
    task automatic check_board();
        logic [8:0] o = '0, w = '0;
        for (int i = 0; i < 9; i++) begin o[i] = occ[i]; w[i] = own[i]; end
        check("square1to9", 32'(square1to9), 32'(o));
        check("owner1to9", 32'(owner1to9), 32'(w));
        check("last_square", 32'(last_square), 32'(last_m));
    endtask
    task automatic clear_board();
        @(negedge pclk) board_clr = 1'b1;
        @(negedge pclk) board_clr = 1'b0;
        clr_model();
        #1 check_board();
    endtask
    task automatic click(input int x, input int y);
        int idx = decode(x, y);
        @(negedge pclk);
        uart_mode = 1'b0; uart_en = 1'b0; mouse_xpos = 12'(x); mouse_ypos = 12'(y); mouse_left = 1'b1;
        @(negedge pclk) mouse_left = 1'b0;
        if (idx >= 0 && !occ[idx]) begin pend_v_m = 1; pend_sq_m = idx; end
    endtask
    task automatic send(input bit abort);
        int s0 = n_start, d0 = n_done;
        bit exp_s = pend_v_m, exp_d = pend_v_m && !abort;
        logic [7:0] exp_tx = frame(pend_sq_m, int'(playerID));
        @(negedge pclk);
        uart_mode = 1'b0; uart_en = 1'b1; write_uart_en = 1'b1;
        @(negedge pclk) write_uart_en = 1'b0;
        check("tx_start_lat", 32'(u_if.tx_start), 32'(exp_s));
        if (exp_s) check("tx_data", 32'(u_if.tx_data), 32'(exp_tx));
        @(negedge pclk) check("tx_start_single", 32'(u_if.tx_start), 32'(0));
        if (abort) uart_en = 1'b0;
        repeat ($urandom_range(0, 3)) @(negedge pclk);
        u_if.tx_done = 1'b1;
        @(negedge pclk) u_if.tx_done = 1'b0;
        check("tx_done_lat", 32'(rx_tx_done), 32'(exp_d));
        @(negedge pclk) uart_en = 1'b0;
        check("tx_done_pulse", 32'(rx_tx_done), 32'(0));
        @(negedge pclk) #1;
        check("tx_start_count", 32'(n_start - s0), 32'(exp_s));
        check("tx_commit_count", 32'(n_done - d0), 32'(exp_d));
        if (exp_d) begin
            occ[pend_sq_m] = 1; own[pend_sq_m] = playerID; last_m = pend_sq_m; pend_v_m = 0;
        end
        check_board();
    endtask
    task automatic recv(input logic [7:0] b, input bit abort, input bit clr);
        int d0 = n_done, f0 = n_ferr, idx = int'(b) & 15;
        bit ok, exp_d, exp_f;
        ok = (int'(b) >> 6) == 2 && idx <= 8 && ((int'(b) >> 4) & 1) == parity(idx) &&
             ((int'(b) >> 5) & 1) != int'(playerID);
        if (ok) ok = !occ[idx];
        exp_d = ok && !abort && !clr;
        exp_f = !ok && !abort && !clr;
        @(negedge pclk);
        uart_mode = 1'b1; uart_en = 1'b1; write_uart_en = 1'b1;
        @(negedge pclk) write_uart_en = 1'b0;
        repeat ($urandom_range(0, 3)) @(negedge pclk);
        if (abort) begin uart_en = 1'b0; @(negedge pclk); end
        u_if.rx_data = b; u_if.rx_valid = 1'b1; board_clr = clr;
        @(negedge pclk) begin u_if.rx_valid = 1'b0; board_clr = 1'b0; end
        if (clr) clr_model();
        if (exp_d) begin occ[idx] = 1; own[idx] = b[5]; last_m = idx; end
        check("rx_done_lat", 32'(rx_tx_done), 32'(exp_d));
        check("frame_err", 32'(frame_err), 32'(exp_f));
        @(negedge pclk) uart_en = 1'b0;
        check("rx_done_pulse", 32'(rx_tx_done), 32'(0));
        check("frame_err_pulse", 32'(frame_err), 32'(0));
        @(negedge pclk) #1;
        check("rx_commit_count", 32'(n_done - d0), 32'(exp_d));
        check("frame_err_count", 32'(n_ferr - f0), 32'(exp_f));
        check_board();
    endtask
    function automatic logic [7:0] rand_frame();
        int idx = $urandom_range(0, 9) == 0 ? int'($urandom_range(9, 15)) : int'($urandom_range(0, 8));
        int snd = $urandom_range(0, 9) < 7 ? 1 - int'(playerID) : int'(playerID);
        int par = $urandom_range(0, 9) == 0 ? 1 - parity(idx) : parity(idx);
        int syn = $urandom_range(0, 9) == 0 ? int'($urandom_range(0, 3)) : 2;
        return 8'(syn * 64 + snd * 32 + par * 16 + idx);
    endfunction
    initial begin
        u_if.tx_done = 1'b0; u_if.rx_valid = 1'b0; u_if.rx_data = '0;
        clr_model();
        repeat (3) @(negedge pclk);
        rst = 1'b0;
        check_board();
        check("reset_tx_start", 32'(u_if.tx_start), 32'(0));
        check("reset_done", 32'(rx_tx_done), 32'(0));
        check("reset_frame_err", 32'(frame_err), 32'(0));
        check("reset_timeout", 32'(link_timeout), 32'(0));
        repeat (5) @(negedge pclk);
        #1 check("idle_no_tx_start", 32'(n_start), 32'(0));
        playerID = 1'b0;
        click(400, 300);
        send(1'b0);
        check("tx_frame_sq4", 32'(last_tx), 32'(frame(4, 0)));
        recv(8'hB8, 1'b0, 1'b0);
        recv(8'hA8, 1'b0, 1'b0);
        recv(8'h09, 1'b0, 1'b0);
        recv(8'hA4, 1'b0, 1'b0);
        clear_board();
        click(340, 100);
        send(1'b0);
        click(100, 600);
        send(1'b1);
        send(1'b0);
        recv(8'hB8, 1'b0, 1'b1);
        for (int t = 0; t < 400; t++) begin
            int r = $urandom_range(0, 99);
            if (r < 30) begin
                playerID = 1'($urandom_range(0, 1));
                if ($urandom_range(0, 3) == 0) click(int'($urandom_range(0, 1100)), int'($urandom_range(0, 800)));
                else click(int'($urandom_range(0, 1023)), int'($urandom_range(0, 767)));
            end else if (r < 55) send($urandom_range(0, 4) == 0);
            else if (r < 94) recv(rand_frame(), $urandom_range(0, 9) == 0, $urandom_range(0, 19) == 0);
            else clear_board();
        end
`ifdef MOVE_LINK_TIMEOUT_EN
        @(negedge pclk);
        uart_mode = 1'b1; uart_en = 1'b1; write_uart_en = 1'b1;
        @(negedge pclk) write_uart_en = 1'b0;
        repeat (49) @(negedge pclk);
        check("timeout_early", 32'(link_timeout), 32'(0));
        @(negedge pclk) check("timeout_set", 32'(link_timeout), 32'(1));
        uart_en = 1'b0;
        clear_board();
        check("timeout_cleared", 32'(link_timeout), 32'(0));
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
